gpio_bank: RTL and testbench

//  Parametrised memory-mapped GPIO bank for the SOC IO page, successor to the single-register gpio_ip.

---
 rtl/gpio_bank.sv | 118 +++++++++++
 tb/tb_gpio_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank - memory-mapped GPIO bank: direction, atomic SET/CLR/TOGGLE,
// synchronised inputs and rise/fall edge capture with W1C interrupt status. Rev 1.0
`default_nettype none

module gpio_bank #(
  parameter int               NPINS       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NPINS-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sel,
  input  logic [3:0]       addr,
  input  logic [3:0]       wmask,
  input  logic [31:0]      wdata,
  input  logic             rstrb,
  output logic [31:0]      rdata,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] ADDR_DATA_OUT = 4'd0;
  localparam logic [3:0] ADDR_DIR      = 4'd1;
  localparam logic [3:0] ADDR_DATA_IN  = 4'd2;
  localparam logic [3:0] ADDR_SET      = 4'd3;
  localparam logic [3:0] ADDR_CLR      = 4'd4;
  localparam logic [3:0] ADDR_TOGGLE   = 4'd5;
  localparam logic [3:0] ADDR_RISE_EN  = 4'd6;
  localparam logic [3:0] ADDR_FALL_EN  = 4'd7;
  localparam logic [3:0] ADDR_STATUS   = 4'd8;

  logic [NPINS-1:0] data_out, dir, rise_en, fall_en, status;
  logic [NPINS-1:0] prev, din, rise, fall, w1c, status_next;
  logic [NPINS-1:0] lane_en, wval;
  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
  logic [31:0] rd_next;
  logic        we, rd;
  logic        unused_bits;

  // Per-pin byte-lane enable and masked write value; bits >= NPINS never reach a register.
  for (genvar i = 0; i < NPINS; i++) begin : g_lanes
    assign lane_en[i] = wmask[i/8];
    assign wval[i]    = wdata[i] & wmask[i/8];
  end

  assign unused_bits = ^{wdata, wmask};

  assign we   = sel & (|wmask);
  assign rd   = sel & rstrb;
  assign din  = sync_q[SYNC_STAGES-1];
  assign rise = din & ~prev;
  assign fall = ~din & prev;
  assign w1c  = (we && addr == ADDR_STATUS) ? wval : '0;

  // A fresh edge overrides a same-cycle W1C of the same bit.
  assign status_next = (status & ~w1c) | (rise & rise_en) | (fall & fall_en);

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_DATA_OUT: rd_next[NPINS-1:0] = data_out;
      ADDR_DIR:      rd_next[NPINS-1:0] = dir;
      ADDR_DATA_IN:  rd_next[NPINS-1:0] = din;
      ADDR_RISE_EN:  rd_next[NPINS-1:0] = rise_en;
      ADDR_FALL_EN:  rd_next[NPINS-1:0] = fall_en;
      ADDR_STATUS:   rd_next[NPINS-1:0] = status;
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev   <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out <= RESET_OUT;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      irq      <= 1'b0;
      rdata    <= '0;
    end else begin
      status <= status_next;
      irq    <= |status_next;
      if (rd) begin
        rdata <= rd_next;
      end
      if (we) begin
        case (addr)
          ADDR_DATA_OUT: data_out <= (data_out & ~lane_en) | wval;
          ADDR_DIR:      dir      <= (dir & ~lane_en) | wval;
          ADDR_SET:      data_out <= data_out | wval;
          ADDR_CLR:      data_out <= data_out & ~wval;
          ADDR_TOGGLE:   data_out <= data_out ^ wval;
          ADDR_RISE_EN:  rise_en  <= (rise_en & ~lane_en) | wval;
          ADDR_FALL_EN:  fall_en  <= (fall_en & ~lane_en) | wval;
          default:       ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank - directed self-checking bench for gpio_bank (NPINS=16, SYNC_STAGES=2).
`default_nettype none

module tb_gpio_bank;

  localparam int          NPINS     = 16;
  localparam logic [15:0] RST_VAL   = 16'h00C3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic [3:0]  addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        rstrb;
  logic [31:0] rdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(
    .NPINS(NPINS),
    .SYNC_STAGES(2),
    .RESET_OUT(RST_VAL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sel(sel),
    .addr(addr),
    .wmask(wmask),
    .wdata(wdata),
    .rstrb(rstrb),
    .rdata(rdata),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wmask = m;
    @(posedge clk);
    #1;
    sel = 1'b0; wmask = 4'b0000;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = a;
    @(posedge clk);
    #1;
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    resetn = 1'b0; sel = 1'b0; addr = '0; wmask = '0; wdata = '0; rstrb = 1'b0; gpio_in = '0;

    // T1: reset state and reads of every offset
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", {16'h0, gpio_out}, {16'h0, RST_VAL});
    check("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus_read(a[3:0], d);
      check($sformatf("rst_rd%0d", a), d, (a == 0) ? {16'h0, RST_VAL} : 32'h0);
    end

    // T2: bits above NPINS ignored, then atomic sequence
    bus_write(4'd0, 32'hFFFF_FFFF, 4'b1111);
    bus_read(4'd0, d);
    check("wide_write", d, 32'h0000_FFFF);
    bus_write(4'd0, 32'h0000_00A5, 4'b1111);
    bus_write(4'd3, 32'h0000_000F, 4'b1111);
    bus_write(4'd4, 32'h0000_0080, 4'b1111);
    bus_write(4'd5, 32'h0000_0003, 4'b1111);
    bus_read(4'd0, d);
    // ((0xA5 | 0x0F) & ~0x80) ^ 0x03 = 0x2C
    check("atomic_rd", d, 32'h0000_002C);
    check("atomic_pins", {16'h0, gpio_out}, 32'h0000_002C);
    bus_write(4'd1, 32'h0000_00FF, 4'b1111);
    check("dir_oe", {16'h0, gpio_oe}, 32'h0000_00FF);

    // Same-cycle read and write of DATA_OUT returns the pre-write value
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = 4'd0; wdata = 32'h0000_1234; wmask = 4'b1111;
    @(posedge clk);
    #1;
    sel = 1'b0; rstrb = 1'b0; wmask = 4'b0000;
    check("rw_same_rd", rdata, 32'h0000_002C);
    check("rw_same_pins", {16'h0, gpio_out}, 32'h0000_1234);

    // T3: byte-lane mask and 1-cycle read latency
    bus_write(4'd0, 32'h0, 4'b1111);
    bus_write(4'd0, 32'h0000_BEEF, 4'b0010);
    bus_read(4'd6, d);
    check("t3_prep", d, 32'h0);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = 4'd0;
    #1;
    check("t3_pre_edge", rdata, 32'h0);
    @(posedge clk);
    #1;
    sel = 1'b0; rstrb = 1'b0;
    check("t3_latency", rdata, 32'h0000_BE00);
    @(posedge clk);
    #1;
    check("t3_hold", rdata, 32'h0000_BE00);

    // T4: rising edge on pin0 raises irq exactly three edges later
    bus_write(4'd6, 32'h0000_0001, 4'b1111);
    @(posedge clk);
    #1;
    gpio_in[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t4_irq_k1", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("t4_irq_k2", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("t4_irq_k3", {31'h0, irq}, 32'h1);
    bus_read(4'd8, d);
    check("t4_status", d, 32'h0000_0001);
    bus_read(4'd2, d);
    check("t4_data_in", d, 32'h0000_0001);
    bus_write(4'd8, 32'h0000_0001, 4'b1111);
    check("t4_w1c_irq", {31'h0, irq}, 32'h0);
    bus_read(4'd8, d);
    check("t4_w1c_status", d, 32'h0);

    // T5: W1C colliding with a new fall on pin1 leaves the bit set
    bus_write(4'd7, 32'h0000_0002, 4'b1111);
    gpio_in[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_rise_irq", {31'h0, irq}, 32'h0);
    gpio_in[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_fall_irq", {31'h0, irq}, 32'h1);
    bus_read(4'd8, d);
    check("t5_status", d, 32'h0000_0002);
    gpio_in[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    gpio_in[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    bus_write(4'd8, 32'h0000_0002, 4'b1111);
    check("t5_collide_irq", {31'h0, irq}, 32'h1);
    bus_read(4'd8, d);
    check("t5_collide_status", d, 32'h0000_0002);
    bus_write(4'd8, 32'h0000_0002, 4'b1111);
    check("t5_clear_irq", {31'h0, irq}, 32'h0);

    // T6: writes to unmapped offset and DATA_IN change nothing
    bus_write(4'd12, 32'hFFFF_FFFF, 4'b1111);
    bus_write(4'd2, 32'hFFFF_FFFF, 4'b1111);
    bus_read(4'd0, d);
    check("t6_data_out", d, 32'h0000_BE00);
    bus_read(4'd1, d);
    check("t6_dir", d, 32'h0000_00FF);
    bus_read(4'd6, d);
    check("t6_rise_en", d, 32'h0000_0001);
    bus_read(4'd7, d);
    check("t6_fall_en", d, 32'h0000_0002);
    bus_read(4'd8, d);
    check("t6_status", d, 32'h0);
    bus_read(4'd2, d);
    check("t6_data_in", d, 32'h0000_0001);
    check("t6_irq", {31'h0, irq}, 32'h0);

    // Async reset in the middle of a read
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = 4'd0;
    @(posedge clk);
    #1;
    check("t6_rd_before", rdata, 32'h0000_BE00);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_rdata", rdata, 32'h0);
    check("t6_async_pins", {16'h0, gpio_out}, {16'h0, RST_VAL});
    check("t6_async_oe", {16'h0, gpio_oe}, 32'h0);
    sel = 1'b0; rstrb = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    // pin0 is still high, so the sync chain sees a rise after release; enables are 0
    repeat (5) @(posedge clk);
    #1;
    check("t6_post_rst_irq", {31'h0, irq}, 32'h0);
    bus_read(4'd8, d);
    check("t6_post_rst_status", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
